// File: rtl/change_logger_pkg.sv
// Shared defaults and types for the change logger and its event FIFO.
package change_logger_pkg;

  localparam int unsigned CL_WIDTH = 7;
  localparam int unsigned CL_TS_W  = 16;
  localparam int unsigned CL_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push_ok, input logic pop_ok);
    return fifo_op_e'({push_ok, pop_ok});
  endfunction

endpackage

// File: rtl/change_logger_defs.vh
// Default parameters and entry layout for change_logger, shared with benches.
`ifndef CHANGE_LOGGER_DEFS_VH
`define CHANGE_LOGGER_DEFS_VH

`define CL_WIDTH_DEF  7
`define CL_TS_W_DEF   16
`define CL_DEPTH_DEF  8

// Entry word is {timestamp, vector}; the vector occupies the low bits.
`define CL_VEC_LSB(w, t)    0
`define CL_TS_LSB(w, t)     (w)
`define CL_ENTRY_W(w, t)    ((t) + (w))

`endif

// File: rtl/change_logger_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo
  import change_logger_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;
  fifo_op_e      op;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    op      = fifo_op(push_ok, pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    case (op)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = cnt_q + CW'(1);
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d    = cnt_q - CW'(1);
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/change_logger.sv
// Logs {timestamp, vector} whenever the observed vector changes (or on the first enabled edge after arming).
module change_logger
  import change_logger_pkg::*;
#(
  parameter int unsigned WIDTH = CL_WIDTH,
  parameter int unsigned TS_W  = CL_TS_W,
  parameter int unsigned DEPTH = CL_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [WIDTH-1:0]          sample_in,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [TS_W+WIDTH-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             armed_q, armed_d;
  logic             ovf_q, ovf_d;
  logic             event_w, drop;
  logic             fifo_full, fifo_empty;

  always_comb begin
    event_w = en & (armed_q | (sample_in != prev_q));
    // A pop on the same edge frees a slot, so only a non-popping full FIFO drops.
    drop    = event_w & fifo_full & ~(rd_en & ~fifo_empty);

    ts_d    = en ? ts_q + TS_W'(1) : ts_q;
    prev_d  = en ? sample_in : prev_q;

    armed_d = armed_q;
    if (!en)          armed_d = 1'b1;
    else if (event_w) armed_d = 1'b0;

    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      prev_q  <= '0;
      armed_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .DW    (TS_W + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (event_w),
    .pop   (rd_en),
    .din   ({ts_q, sample_in}),
    .dout  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign rd_valid = ~fifo_empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_change_logger.sv
// Bench for change_logger: directed scenarios plus random traffic against a queue-based reference model.
module tb_change_logger;

  localparam int unsigned W     = 7;
  localparam int unsigned DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] sample_in;
  logic         rd_en;
  logic         clr_ovf;

  logic         rd_valid_a, ovf_a;
  logic [22:0]  rd_data_a;
  logic [3:0]   count_a;
  logic         rd_valid_b, ovf_b;
  logic [10:0]  rd_data_b;
  logic [3:0]   count_b;

  change_logger u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sample_in (sample_in),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid_a),
    .rd_data   (rd_data_a),
    .count     (count_a),
    .overflow  (ovf_a),
    .clr_ovf   (clr_ovf)
  );

  change_logger #(.TS_W(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sample_in (sample_in),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid_b),
    .rd_data   (rd_data_b),
    .count     (count_b),
    .overflow  (ovf_b),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  ts;
    logic [W-1:0] v;
  } ent_t;

  ent_t         q[$];
  int unsigned  m_ts;
  logic [W-1:0] m_prev;
  bit           m_armed;
  bit           m_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts    = 0;
    m_prev  = '0;
    m_armed = 1'b1;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit e, input logic [W-1:0] s, input bit r, input bit c);
    bit ev;
    bit drop;
    ent_t n;
    ev   = e && (m_armed || (s != m_prev));
    drop = 1'b0;
    if (r && q.size() > 0) q.delete(0);
    if (ev) begin
      if (q.size() < DEPTH) begin
        n.ts = m_ts;
        n.v  = s;
        q.push_back(n);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop)   m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (!e)      m_armed = 1'b1;
    else if (ev) m_armed = 1'b0;
    if (e) begin
      m_prev = s;
      m_ts++;
    end
  endtask

  task automatic check_all();
    int unsigned t;
    logic [W-1:0] v;
    chk("rd_valid16", 32'(rd_valid_a), 32'(q.size() != 0));
    chk("count16",    32'(count_a),    32'(q.size()));
    chk("overflow16", 32'(ovf_a),      32'(m_ovf));
    chk("rd_valid4",  32'(rd_valid_b), 32'(q.size() != 0));
    chk("count4",     32'(count_b),    32'(q.size()));
    chk("overflow4",  32'(ovf_b),      32'(m_ovf));
    if (q.size() != 0) begin
      t = q[0].ts;
      v = q[0].v;
      chk("rd_data16", 32'(rd_data_a), 32'({t[15:0], v}));
      chk("rd_data4",  32'(rd_data_b), 32'({t[3:0], v}));
    end
  endtask

  // Called at a falling edge; drives inputs, advances the model, checks after the next rising edge.
  task automatic step(input bit e, input logic [W-1:0] s, input bit r, input bit c);
    en = e; sample_in = s; rd_en = r; clr_ovf = c;
    model_step(e, s, r, c);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    en = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; sample_in = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid_a), 32'd0);
    chk("rst_count",    32'(count_a),    32'd0);
    chk("rst_ovf",      32'(ovf_a),      32'd0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst_n = 1'b0; en = 1'b0; sample_in = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(negedge clk);

    // Held vector: one entry, stamped 0.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 7'b1001000, 1'b0, 1'b0);
    chk("held_count", 32'(count_a), 32'd1);
    chk("held_entry", 32'(rd_data_a), 32'h0000048);

    // Two changes at ts 5 and 10, then drained.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 7'b1001000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 7'b0011000, 1'b0, 1'b0);
    step(1'b1, 7'b1000000, 1'b0, 1'b0);
    chk("seq_count", 32'(count_a), 32'd3);
    chk("seq_e0", 32'(rd_data_a), 32'({16'd0, 7'b1001000}));
    step(1'b1, 7'b1000000, 1'b1, 1'b0);
    chk("seq_e1", 32'(rd_data_a), 32'({16'd5, 7'b0011000}));
    step(1'b1, 7'b1000000, 1'b1, 1'b0);
    chk("seq_e2", 32'(rd_data_a), 32'({16'd10, 7'b1000000}));
    step(1'b1, 7'b1000000, 1'b1, 1'b0);
    step(1'b1, 7'b1000000, 1'b1, 1'b0);

    // Overflow after ten toggles, then clear.
    do_reset();
    a = 7'h15; b = 7'h2a;
    for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? a : b, 1'b0, 1'b0);
    chk("ovf_count", 32'(count_a), 32'd8);
    chk("ovf_set",   32'(ovf_a),   32'd1);
    step(1'b1, b, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf_a), 32'd0);

    // Full with simultaneous pop and change: accepted as tail, no overflow.
    step(1'b1, 7'h33, 1'b1, 1'b0);
    chk("fullpop_count", 32'(count_a), 32'd8);
    chk("fullpop_ovf",   32'(ovf_a),   32'd0);

    // Drop and clear on the same edge: drop wins.
    step(1'b1, 7'h44, 1'b0, 1'b1);
    chk("dropclr_ovf", 32'(ovf_a), 32'd1);
    for (int i = 0; i < 9; i++) step(1'b1, 7'h44, 1'b1, 1'b0);

    // 4-bit timestamps wrap with reads keeping up.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 7'(i + 1), 1'b1, 1'b0);
      chk("wrap_ts4", 32'(rd_data_b[10:7]), 32'(i % 16));
    end
    en = 1'b1; sample_in = 7'h7f;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(rd_valid_b), 32'd0);
    chk("async_count", 32'(count_b),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Random traffic with occasional enable gaps, reads and clears.
    s = 7'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) s = 7'($urandom);
      step($urandom_range(0, 9) != 0, s, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      if (i == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
